// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo: synchronous single-clock FIFO with occupancy count, status flags
// and sticky overflow/underflow error flags.
//
// Optional feature: define PARAM_FIFO_FWFT_EN for first-word-fall-through
// output. Without it, reads are registered with one cycle of latency.
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_wr_en          write request
//   i_wr_data        write word
//   i_rd_en          read request (pop acknowledge in FWFT mode)
//   i_clr_err        synchronous clear of the sticky error flags
//   o_rd_data        read word
//   o_rd_valid       o_rd_data qualifier
//   o_count          occupancy, 0..DEPTH
//   o_full           count == DEPTH
//   o_empty          count == 0
//   o_almost_full    count >= AF_LEVEL
//   o_almost_empty   count <= AE_LEVEL
//   o_overflow       sticky: write rejected because the FIFO was full
//   o_underflow      sticky: read rejected because the FIFO was empty
// -----------------------------------------------------------------------------
module param_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_accept;
    logic w_wr_accept;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // A read frees the head slot in the same edge, so a write alongside a
    // read is accepted even when full.
    assign w_rd_accept = i_rd_en && !w_empty;
    assign w_wr_accept = i_wr_en && (!w_full || i_rd_en);

    assign w_ovf_set = i_wr_en && !w_wr_accept;
    assign w_unf_set = i_rd_en && w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr_accept && !w_rd_accept) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_rd_accept && !w_wr_accept) begin
                r_count <= r_count - CNT_ONE;
            end
            // Setting an error wins over a coincident clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (i_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; reset only discards it via pointers.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    // Head word is presented directly; zero while empty so reset shows 0.
    assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_rd_valid = !w_empty;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
`endif

    assign o_count        = r_count;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= CNT_AF);
    assign o_almost_empty = (r_count <= CNT_AE);
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of each stored word.
REQ-002 Parameter ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (default 8).
REQ-003 Parameter AF_LEVEL, 6, almost_full threshold (occupancy >= AF_LEVEL).
REQ-004 Parameter AE_LEVEL, 2, almost_empty threshold (occupancy <= AE_LEVEL).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  DATA_WIDTH  write word.
REQ-010 rd_en  input  1  read request (acknowledge in FWFT mode).
REQ-011 clr_err  input  1  synchronous clear of sticky error flags.
REQ-012 rd_data  output  DATA_WIDTH  read word.
REQ-013 rd_valid  output  1  rd_data qualifier.
REQ-014 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Read accepted iff rd_en && !empty; write accepted iff wr_en && (!full || rd_en).
REQ-018 Storage: DEPTH x DATA_WIDTH array; write and read pointers ADDR_WIDTH bits, increment by 1 per accepted op, wrap DEPTH-1 -> 0 naturally.
REQ-019 count: +1 write-only, -1 read-only, unchanged when both accepted or neither.
REQ-020 Write-only when full: rejected, storage/pointers/count unchanged, overflow set.
REQ-021 Read when empty: rejected, underflow set; a simultaneous write is still accepted (count 0 -> 1).
REQ-022 Read+write when full: both accepted, head word read out, new word written to freed slot, count stays DEPTH.
REQ-023 Flags combinational from count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-024 Standard mode: rd_data registered, updated on the edge of an accepted read with the head word (1-cycle latency); rd_valid high exactly the cycle after each accepted read; rd_data holds otherwise.
REQ-025 overflow/underflow stay set until clr_err; if set condition and clr_err coincide, flag set wins.
REQ-026 Data ordering strictly first-in first-out; no word lost or duplicated across wrap-around.

Reset
REQ-027 rst_n low asynchronously forces: pointers 0, count 0, rd_data 0, rd_valid 0, overflow 0, underflow 0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-028 Storage array not reset; reset mid-operation discards all contents.
REQ-029 Reset release synchronous to clk; first op accepted on the first rising edge with rst_n high.

Configuration
REQ-030 Macro PARAM_FIFO_FWFT_EN defined: first-word-fall-through; rd_data = head word whenever !empty, rd_valid = !empty, rd_en acknowledges and pops the word; word written into empty FIFO visible one cycle after its write edge.
REQ-031 Macro undefined: standard registered-read behaviour of REQ-024.

Verification
REQ-032 Reset, write 8 words 0x1..0x8 -> full=1, count=8, almost_full=1 after 6th write; 9th write-only -> overflow=1, count stays 8.
REQ-033 From full, read 8 times -> rd_data 0x1..0x8 in order, each with rd_valid one cycle later (standard); empty=1 after 8th; 9th read -> underflow=1.
REQ-034 Fill to 8, simultaneous write 0xA5 + read -> rd_data 0x1, count 8; drain -> 0x2..0x8 then 0xA5.
REQ-035 Empty FIFO, simultaneous write 0x55 + read -> underflow=1, count=1; clr_err -> underflow=0; next read returns 0x55.
REQ-036 Write 20 words with interleaved reads keeping count 3..5 -> pointers wrap twice, output sequence matches input exactly.
REQ-037 Assert rst_n low with count=5 mid-burst -> all REQ-027 values immediately, before next clk edge; FWFT build: after one write of 0x77, rd_data=0x77 and rd_valid=1 without rd_en.
